// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencer: per-stage stall vector, multicycle FSM
// state and the canonical stall patterns for each requesting stage.
package pipe_ctrl_pkg;

    // Bit order {wb, mem, ex, id, if, pc}; a 1 holds that register.
    typedef logic [5:0] stall_t;

    typedef enum logic {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_t;

    localparam stall_t STALL_NONE = 6'b000000;
    localparam stall_t STALL_IF   = 6'b000011;
    localparam stall_t STALL_ID   = 6'b000111;
    localparam stall_t STALL_EX   = 6'b001111;
    localparam stall_t STALL_MEM  = 6'b011111;

endpackage

// File: rtl/pipe_ctrl_mc_tracker.sv
// Multicycle-EX handshake FSM (start/done/abort) plus a saturating hang watchdog
// whose sticky timeout flag survives until reset.
module pipe_ctrl_mc_tracker
    import pipe_ctrl_pkg::*;
#(
    parameter int MC_MAX_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic done_i,
    input  logic exc_i,
    input  logic mem_stall_i,
    output logic go_o,
    output logic abort_o,
    output logic busy_o,
    output logic ex_stall_o,
    output logic timeout_o
);

    localparam int WD_W = $clog2(MC_MAX_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MC_MAX_CYCLES - 1);

    mc_state_t       state_q, state_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            to_q, to_d;
    logic            hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MC_IDLE;
            wd_q    <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wd_d       = wd_q;
        to_d       = to_q;
        go_o       = 1'b0;
        abort_o    = 1'b0;
        ex_stall_o = 1'b0;
        hit        = 1'b0;
        case (state_q)
            MC_IDLE: begin
                // A done seen while idle is stale and deliberately ignored.
                ex_stall_o = start_i;
                wd_d       = '0;
                if (start_i && !exc_i && !mem_stall_i) begin
                    state_d = MC_BUSY;
                    go_o    = 1'b1;
                end
            end
            MC_BUSY: begin
                ex_stall_o = !done_i;
                hit        = (wd_q == WD_LAST);
                if (hit) begin
                    to_d = 1'b1;
                end
                if (exc_i) begin
                    state_d = MC_IDLE;
                    abort_o = 1'b1;
                    wd_d    = '0;
                end else if (done_i) begin
                    state_d = MC_IDLE;
                    wd_d    = '0;
                end else if (!hit) begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: state_d = MC_IDLE;
        endcase
    end

    assign busy_o    = (state_q == MC_BUSY);
    assign timeout_o = to_q | hit;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall priority, exception flush/redirect and optional
// performance counters (enabled by defining PIPE_PERF_CNT_EN).
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MC_MAX_CYCLES = 64,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_stallreq_i,
    input  logic             id_stallreq_i,
    input  logic             ex_mc_start_i,
    input  logic             ex_mc_done_i,
    input  logic             mem_stallreq_i,
    input  logic             exc_i,
    input  logic [31:0]      exc_pc_i,
    output logic [5:0]       stall_o,
    output logic             flush_o,
    output logic [31:0]      new_pc_o,
    output logic             mc_go_o,
    output logic             mc_abort_o,
    output logic             mc_busy_o,
    output logic             mc_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] mc_cnt_o
);

    logic mc_go, mc_abort, mc_ex_stall;

    pipe_ctrl_mc_tracker #(
        .MC_MAX_CYCLES(MC_MAX_CYCLES)
    ) u_mc_tracker (
        .clk        (clk),
        .rst        (rst),
        .start_i    (ex_mc_start_i),
        .done_i     (ex_mc_done_i),
        .exc_i      (exc_i),
        .mem_stall_i(mem_stallreq_i),
        .go_o       (mc_go),
        .abort_o    (mc_abort),
        .busy_o     (mc_busy_o),
        .ex_stall_o (mc_ex_stall),
        .timeout_o  (mc_timeout_o)
    );

    // Request paths are combinational, so reset masks them to keep outputs quiet.
    always_comb begin
        stall_o  = STALL_NONE;
        flush_o  = 1'b0;
        new_pc_o = '0;
        if (rst) begin
            stall_o = STALL_NONE;
        end else if (exc_i) begin
            flush_o  = 1'b1;
            new_pc_o = exc_pc_i;
        end else if (mem_stallreq_i) begin
            stall_o = STALL_MEM;
        end else if (mc_ex_stall) begin
            stall_o = STALL_EX;
        end else if (id_stallreq_i) begin
            stall_o = STALL_ID;
        end else if (if_stallreq_i) begin
            stall_o = STALL_IF;
        end
    end

    assign mc_go_o    = mc_go & !rst;
    assign mc_abort_o = mc_abort & !rst;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] mc_cnt_q, mc_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + ((stall_o != STALL_NONE) ? CNT_W'(1) : CNT_W'(0));
        mc_cnt_d    = mc_cnt_q + (mc_busy_o ? CNT_W'(1) : CNT_W'(0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            mc_cnt_q    <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            mc_cnt_q    <= mc_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign mc_cnt_o    = mc_cnt_q;
`else
    assign stall_cnt_o = '0;
    assign mc_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios then randomized traffic,
// all checked against a cycle-level behavioural model.
module tb_pipe_ctrl;

    localparam int MAXC  = 8;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             if_stallreq_i, id_stallreq_i, ex_mc_start_i, ex_mc_done_i;
    logic             mem_stallreq_i, exc_i;
    logic [31:0]      exc_pc_i;
    logic [5:0]       stall_o;
    logic             flush_o;
    logic [31:0]      new_pc_o;
    logic             mc_go_o, mc_abort_o, mc_busy_o, mc_timeout_o;
    logic [CNT_W-1:0] stall_cnt_o, mc_cnt_o;

    pipe_ctrl #(
        .MC_MAX_CYCLES(MAXC),
        .CNT_W        (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_stallreq_i (if_stallreq_i),
        .id_stallreq_i (id_stallreq_i),
        .ex_mc_start_i (ex_mc_start_i),
        .ex_mc_done_i  (ex_mc_done_i),
        .mem_stallreq_i(mem_stallreq_i),
        .exc_i         (exc_i),
        .exc_pc_i      (exc_pc_i),
        .stall_o       (stall_o),
        .flush_o       (flush_o),
        .new_pc_o      (new_pc_o),
        .mc_go_o       (mc_go_o),
        .mc_abort_o    (mc_abort_o),
        .mc_busy_o     (mc_busy_o),
        .mc_timeout_o  (mc_timeout_o),
        .stall_cnt_o   (stall_cnt_o),
        .mc_cnt_o      (mc_cnt_o)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: is the unit busy, which busy cycle (1-based) is this, sticky timeout.
    bit     m_busy;
    int     m_ord;
    bit     m_to;
    longint m_scnt, m_mcnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_ord  = 0;
        m_to   = 1'b0;
        m_scnt = 0;
        m_mcnt = 0;
    endtask

    function automatic logic [5:0] exp_stall();
        logic ex_wait;
        ex_wait = m_busy ? !ex_mc_done_i : ex_mc_start_i;
        if (exc_i)          return 6'b000000;
        if (mem_stallreq_i) return 6'b011111;
        if (ex_wait)        return 6'b001111;
        if (id_stallreq_i)  return 6'b000111;
        if (if_stallreq_i)  return 6'b000011;
        return 6'b000000;
    endfunction

    function automatic bit exp_to();
        return m_to || (m_busy && m_ord >= MAXC);
    endfunction

    task automatic model_check();
        logic [CNT_W-1:0] es, em;
`ifdef PIPE_PERF_CNT_EN
        es = CNT_W'(m_scnt);
        em = CNT_W'(m_mcnt);
`else
        es = '0;
        em = '0;
`endif
        chk("stall", 32'(stall_o), 32'(exp_stall()));
        chk("flush", 32'(flush_o), 32'(exc_i));
        chk("new_pc", new_pc_o, exc_i ? exc_pc_i : 32'h0);
        chk("go", 32'(mc_go_o), 32'(!m_busy && ex_mc_start_i && !exc_i && !mem_stallreq_i));
        chk("abort", 32'(mc_abort_o), 32'(m_busy && exc_i));
        chk("busy", 32'(mc_busy_o), 32'(m_busy));
        chk("timeout", 32'(mc_timeout_o), 32'(exp_to()));
        chk("stall_cnt", stall_cnt_o, es);
        chk("mc_cnt", mc_cnt_o, em);
    endtask

    task automatic model_advance();
        if (exp_stall() != 6'b0) m_scnt++;
        if (m_busy) m_mcnt++;
        m_to = exp_to();
        if (m_busy) begin
            if (exc_i || ex_mc_done_i) begin
                m_busy = 1'b0;
                m_ord  = 0;
            end else begin
                m_ord++;
            end
        end else if (ex_mc_start_i && !exc_i && !mem_stallreq_i) begin
            m_busy = 1'b1;
            m_ord  = 1;
        end
    endtask

    task automatic drive(input logic st, input logic dn, input logic ifr, input logic idr,
                         input logic mem, input logic ex, input logic [31:0] pc);
        ex_mc_start_i  = st;
        ex_mc_done_i   = dn;
        if_stallreq_i  = ifr;
        id_stallreq_i  = idr;
        mem_stallreq_i = mem;
        exc_i          = ex;
        exc_pc_i       = pc;
    endtask

    task automatic settle();
        #1;
        model_check();
    endtask

    task automatic tick();
        @(posedge clk);
        model_advance();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        settle();
        chk("rst_stall", 32'(stall_o), 32'h0);
        chk("rst_busy", 32'(mc_busy_o), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Single-cycle decode hazard
        drive(0, 0, 0, 1, 0, 0, 32'h0);
        settle();
        chk("id_stall", 32'(stall_o), 32'h07);
        tick();
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        settle();
        chk("id_release", 32'(stall_o), 32'h00);
        tick();

        // MEM outranks ID
        drive(0, 0, 1, 1, 1, 0, 32'h0);
        settle();
        chk("mem_id", 32'(stall_o), 32'h1F);
        tick();

        // Multicycle op completing after five stalled cycles
        drive(1, 0, 0, 0, 0, 0, 32'h0);
        settle();
        chk("mc_go", 32'(mc_go_o), 32'h1);
        chk("mc_start_stall", 32'(stall_o), 32'h0F);
        tick();
        for (int k = 1; k < 5; k++) begin
            settle();
            chk("mc_busy_stall", 32'(stall_o), 32'h0F);
            chk("mc_go_once", 32'(mc_go_o), 32'h0);
            tick();
        end
        drive(0, 1, 0, 0, 0, 0, 32'h0);
        settle();
        chk("mc_done_stall", 32'(stall_o), 32'h00);
        tick();
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        settle();
        chk("mc_done_idle", 32'(mc_busy_o), 32'h0);
        tick();

        // Exception in the third busy cycle aborts the unit
        drive(1, 0, 0, 0, 0, 0, 32'h0);
        settle();
        tick();
        settle();
        tick();
        settle();
        tick();
        drive(1, 1, 0, 0, 0, 1, 32'hBFC0_0380);
        settle();
        chk("exc_flush", 32'(flush_o), 32'h1);
        chk("exc_pc", new_pc_o, 32'hBFC0_0380);
        chk("exc_abort", 32'(mc_abort_o), 32'h1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        settle();
        chk("exc_idle", 32'(mc_busy_o), 32'h0);
        chk("exc_abort_pulse", 32'(mc_abort_o), 32'h0);
        tick();

        // Watchdog: unit never answers
        drive(1, 0, 0, 0, 0, 0, 32'h0);
        settle();
        tick();
        for (int k = 1; k <= 10; k++) begin
            settle();
            chk("wd_timeout", 32'(mc_timeout_o), 32'(k >= MAXC));
            tick();
        end
        drive(0, 1, 0, 0, 0, 0, 32'h0);
        settle();
        tick();
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        settle();
        chk("wd_sticky", 32'(mc_timeout_o), 32'h1);
        tick();

        // Asynchronous reset in the middle of a busy period
        drive(1, 0, 0, 0, 0, 0, 32'h0);
        settle();
        tick();
        settle();
        tick();
        settle();
        #1;
        rst = 1'b1;
        drive(1, 0, 1, 1, 1, 1, 32'h1234_5678);
        model_reset();
        #1;
        chk("arst_stall", 32'(stall_o), 32'h0);
        chk("arst_flush", 32'(flush_o), 32'h0);
        chk("arst_pc", new_pc_o, 32'h0);
        chk("arst_go", 32'(mc_go_o), 32'h0);
        chk("arst_abort", 32'(mc_abort_o), 32'h0);
        chk("arst_busy", 32'(mc_busy_o), 32'h0);
        chk("arst_timeout", 32'(mc_timeout_o), 32'h0);
        chk("arst_scnt", stall_cnt_o, 32'h0);
        chk("arst_mcnt", mc_cnt_o, 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        rst = 1'b0;
        settle();
        tick();

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            drive($urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 15) == 0,
                  $urandom());
            settle();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
